// File: rtl/reg_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : reg_stack_ctrl
//  Brief    : Stack-pointer sequencer for the banked register-save stack.
//             Turns single-cycle push/pop requests into RAM write and
//             read-then-restore sequences and flags overflow/underflow.
//  Revision : 1.0  initial release
// ============================================================================
module reg_stack_ctrl #(
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic              err_clr,
    output logic [ADDR_W-1:0] stack_addr,
    output logic              stack_wren,
    output logic              restore_en,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   sp,
    output logic              full,
    output logic              empty,
    output logic              ovf_err,
    output logic              unf_err
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PUSH_WR = 2'd1,
        ST_POP_RD  = 2'd2,
        ST_POP_LD  = 2'd3
    } state_t;

    localparam logic [ADDR_W:0]   c_depth     = (ADDR_W+1)'(1 << ADDR_W);
    localparam logic [ADDR_W:0]   c_sp_one    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_addr_one  = ADDR_W'(1);
    localparam logic [1:0]        c_wait_last = 2'(RD_LAT - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W:0]   r_sp;
    logic [ADDR_W:0]   w_sp_nxt;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [ADDR_W-1:0] w_addr_top;
    logic [1:0]        r_wait;
    logic [1:0]        w_wait_nxt;
    logic              r_wren;
    logic              w_wren_nxt;
    logic              r_restore;
    logic              w_restore_nxt;
    logic              r_busy;
    logic              w_busy_nxt;
    logic              r_done;
    logic              w_done_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic              r_unf;
    logic              w_unf_nxt;
    logic              w_ovf_set;
    logic              w_unf_set;
    logic              w_full;
    logic              w_empty;

    // full/empty are the only combinational outputs: pure decodes of sp
    assign w_full  = (r_sp == c_depth);
    assign w_empty = (r_sp == '0);

    // Top-of-stack address; when sp == depth the low bits are 0 and wrap to the last entry
    assign w_addr_top = r_sp[ADDR_W-1:0] - c_addr_one;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and next-output decode; flush overrides every state
    always_comb begin
        w_state_nxt   = r_state;
        w_sp_nxt      = r_sp;
        w_addr_nxt    = r_addr;
        w_wait_nxt    = r_wait;
        w_wren_nxt    = 1'b0;
        w_restore_nxt = 1'b0;
        w_done_nxt    = 1'b0;
        w_ovf_set     = 1'b0;
        w_unf_set     = 1'b0;

        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_sp_nxt    = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // push has priority; a simultaneous pop is silently dropped
                    if (push) begin
                        if (!w_full) begin
                            w_state_nxt = ST_PUSH_WR;
                            w_addr_nxt  = r_sp[ADDR_W-1:0];
                            w_wren_nxt  = 1'b1;
                        end else begin
                            w_ovf_set = 1'b1;
                        end
                    end else if (pop) begin
                        if (!w_empty) begin
                            w_state_nxt = ST_POP_RD;
                            w_addr_nxt  = w_addr_top;
                            w_wait_nxt  = 2'd0;
                        end else begin
                            w_unf_set = 1'b1;
                        end
                    end
                end
                ST_PUSH_WR: begin
                    w_state_nxt = ST_IDLE;
                    w_sp_nxt    = r_sp + c_sp_one;
                    w_done_nxt  = 1'b1;
                end
                ST_POP_RD: begin
                    // RAM q becomes valid RD_LAT edges after the address was presented
                    if (r_wait == c_wait_last) begin
                        w_state_nxt   = ST_POP_LD;
                        w_restore_nxt = 1'b1;
                    end else begin
                        w_wait_nxt = r_wait + 2'd1;
                    end
                end
                ST_POP_LD: begin
                    w_state_nxt = ST_IDLE;
                    w_sp_nxt    = r_sp - c_sp_one;
                    w_done_nxt  = 1'b1;
                end
                default: begin
                    w_state_nxt = ST_IDLE;
                end
            endcase
        end

        w_busy_nxt = (w_state_nxt != ST_IDLE);
        // A fresh error on the same edge as err_clr wins over the clear
        w_ovf_nxt  = w_ovf_set | (r_ovf & ~err_clr);
        w_unf_nxt  = w_unf_set | (r_unf & ~err_clr);
    end

    // Registered datapath and strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sp      <= '0;
            r_addr    <= '0;
            r_wait    <= 2'd0;
            r_wren    <= 1'b0;
            r_restore <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
        end else begin
            r_sp      <= w_sp_nxt;
            r_addr    <= w_addr_nxt;
            r_wait    <= w_wait_nxt;
            r_wren    <= w_wren_nxt;
            r_restore <= w_restore_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_ovf     <= w_ovf_nxt;
            r_unf     <= w_unf_nxt;
        end
    end

    assign stack_addr = r_addr;
    assign stack_wren = r_wren;
    assign restore_en = r_restore;
    assign busy       = r_busy;
    assign done       = r_done;
    assign sp         = r_sp;
    assign full       = w_full;
    assign empty      = w_empty;
    assign ovf_err    = r_ovf;
    assign unf_err    = r_unf;

endmodule
`default_nettype wire

// File: tb/tb_reg_stack_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_reg_stack_ctrl
//  Brief    : Directed self-checking bench for reg_stack_ctrl; instance a uses
//             RD_LAT=1, instance b uses RD_LAT=2.
//  Revision : 1.0  initial release
// ============================================================================
module tb_reg_stack_ctrl;

    logic       clk;
    logic       rst_n;
    logic       push_a, pop_a, flush_a, err_clr_a;
    logic       push_b, pop_b, flush_b, err_clr_b;
    logic [4:0] addr_a, addr_b;
    logic [5:0] sp_a, sp_b;
    logic       wren_a, restore_a, busy_a, done_a, full_a, empty_a, ovf_a, unf_a;
    logic       wren_b, restore_b, busy_b, done_b, full_b, empty_b, ovf_b, unf_b;

    int n_tests;
    int n_fail;

    reg_stack_ctrl #(.ADDR_W(5), .RD_LAT(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .push(push_a), .pop(pop_a), .flush(flush_a),
        .err_clr(err_clr_a), .stack_addr(addr_a), .stack_wren(wren_a),
        .restore_en(restore_a), .busy(busy_a), .done(done_a), .sp(sp_a),
        .full(full_a), .empty(empty_a), .ovf_err(ovf_a), .unf_err(unf_a)
    );

    reg_stack_ctrl #(.ADDR_W(5), .RD_LAT(2)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .push(push_b), .pop(pop_b), .flush(flush_b),
        .err_clr(err_clr_b), .stack_addr(addr_b), .stack_wren(wren_b),
        .restore_en(restore_b), .busy(busy_b), .done(done_b), .sp(sp_b),
        .full(full_b), .empty(empty_b), .ovf_err(ovf_b), .unf_err(unf_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance through one rising edge and settle 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_push_a();
        push_a = 1'b1;
        tick();
        push_a = 1'b0;
        tick();
    endtask

    task automatic do_push_b();
        push_b = 1'b1;
        tick();
        push_b = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({sp_a, addr_a, empty_a, full_a, wren_a, restore_a, busy_a, done_a, ovf_a, unf_a} !==
            {6'd0, 5'd0, 1'b1, 1'b0, 6'b0}) begin
            n_fail++;
            $display("FAIL reset_a: sp=%0d addr=%0d e=%b f=%b wr=%b re=%b bz=%b dn=%b ov=%b un=%b, want sp=0 addr=0 e=1 rest 0",
                     sp_a, addr_a, empty_a, full_a, wren_a, restore_a, busy_a, done_a, ovf_a, unf_a);
        end
        n_tests++;
        if ({sp_b, empty_b, wren_b, restore_b, busy_b, done_b} !== {6'd0, 1'b1, 4'b0}) begin
            n_fail++;
            $display("FAIL reset_b: sp=%0d e=%b wr=%b re=%b bz=%b dn=%b, want sp=0 e=1 strobes 0",
                     sp_b, empty_b, wren_b, restore_b, busy_b, done_b);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_push();
        push_a = 1'b1;
        tick();
        push_a = 1'b0;
        n_tests++;
        if ({wren_a, busy_a, addr_a, done_a, sp_a} !== {1'b1, 1'b1, 5'd0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL push1_wr: wr=%b bz=%b addr=%0d dn=%b sp=%0d, want 1 1 0 0 0",
                     wren_a, busy_a, addr_a, done_a, sp_a);
        end
        tick();
        n_tests++;
        if ({wren_a, busy_a, done_a, sp_a, empty_a} !== {1'b0, 1'b0, 1'b1, 6'd1, 1'b0}) begin
            n_fail++;
            $display("FAIL push1_done: wr=%b bz=%b dn=%b sp=%0d e=%b, want 0 0 1 1 0",
                     wren_a, busy_a, done_a, sp_a, empty_a);
        end
        tick();
        n_tests++;
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL push1_done_pulse: dn=%b, want 0", done_a);
        end
    endtask

    task automatic test_pop_lat1();
        do_push_a();
        do_push_a();
        pop_a = 1'b1;
        tick();
        pop_a = 1'b0;
        n_tests++;
        if ({addr_a, busy_a, restore_a, wren_a} !== {5'd2, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL pop1_rd: addr=%0d bz=%b re=%b wr=%b, want 2 1 0 0", addr_a, busy_a, restore_a, wren_a);
        end
        tick();
        n_tests++;
        if ({restore_a, sp_a, done_a, addr_a} !== {1'b1, 6'd3, 1'b0, 5'd2}) begin
            n_fail++;
            $display("FAIL pop1_ld: re=%b sp=%0d dn=%b addr=%0d, want 1 3 0 2", restore_a, sp_a, done_a, addr_a);
        end
        tick();
        n_tests++;
        if ({restore_a, sp_a, done_a, busy_a} !== {1'b0, 6'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pop1_done: re=%b sp=%0d dn=%b bz=%b, want 0 2 1 0", restore_a, sp_a, done_a, busy_a);
        end
        tick();
    endtask

    task automatic test_pop_lat2();
        do_push_b();
        do_push_b();
        do_push_b();
        pop_b = 1'b1;
        tick();
        pop_b = 1'b0;
        n_tests++;
        if ({addr_b, busy_b, restore_b} !== {5'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pop2_rd0: addr=%0d bz=%b re=%b, want 2 1 0", addr_b, busy_b, restore_b);
        end
        tick();
        n_tests++;
        if ({restore_b, busy_b, done_b} !== {1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pop2_rd1: re=%b bz=%b dn=%b, want 0 1 0", restore_b, busy_b, done_b);
        end
        tick();
        n_tests++;
        if ({restore_b, sp_b} !== {1'b1, 6'd3}) begin
            n_fail++;
            $display("FAIL pop2_ld: re=%b sp=%0d, want 1 3", restore_b, sp_b);
        end
        tick();
        n_tests++;
        if ({restore_b, sp_b, done_b, busy_b} !== {1'b0, 6'd2, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL pop2_done: re=%b sp=%0d dn=%b bz=%b, want 0 2 1 0", restore_b, sp_b, done_b, busy_b);
        end
        tick();
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 30; i++) do_push_a();
        n_tests++;
        if ({full_a, sp_a, empty_a} !== {1'b1, 6'd32, 1'b0}) begin
            n_fail++;
            $display("FAIL fill: full=%b sp=%0d e=%b, want 1 32 0", full_a, sp_a, empty_a);
        end
        push_a = 1'b1;
        tick();
        push_a = 1'b0;
        n_tests++;
        if ({ovf_a, wren_a, sp_a, busy_a, done_a} !== {1'b1, 1'b0, 6'd32, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL ovf: ov=%b wr=%b sp=%0d bz=%b dn=%b, want 1 0 32 0 0", ovf_a, wren_a, sp_a, busy_a, done_a);
        end
        tick();
        n_tests++;
        if (ovf_a !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: ov=%b, want 1", ovf_a);
        end
        err_clr_a = 1'b1;
        tick();
        err_clr_a = 1'b0;
        n_tests++;
        if ({ovf_a, sp_a} !== {1'b0, 6'd32}) begin
            n_fail++;
            $display("FAIL ovf_clr: ov=%b sp=%0d, want 0 32", ovf_a, sp_a);
        end
    endtask

    task automatic test_underflow_simul();
        flush_a = 1'b1;
        tick();
        flush_a = 1'b0;
        n_tests++;
        if ({sp_a, empty_a, full_a, done_a} !== {6'd0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_idle: sp=%0d e=%b f=%b dn=%b, want 0 1 0 0", sp_a, empty_a, full_a, done_a);
        end
        pop_a = 1'b1;
        tick();
        pop_a = 1'b0;
        n_tests++;
        if ({unf_a, restore_a, done_a, busy_a, sp_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL unf: un=%b re=%b dn=%b bz=%b sp=%0d, want 1 0 0 0 0", unf_a, restore_a, done_a, busy_a, sp_a);
        end
        tick();
        n_tests++;
        if ({restore_a, done_a} !== 2'b00) begin
            n_fail++;
            $display("FAIL unf_quiet: re=%b dn=%b, want 0 0", restore_a, done_a);
        end
        push_a = 1'b1;
        pop_a  = 1'b1;
        tick();
        push_a = 1'b0;
        pop_a  = 1'b0;
        n_tests++;
        if ({wren_a, busy_a, addr_a} !== {1'b1, 1'b1, 5'd0}) begin
            n_fail++;
            $display("FAIL simul_wr: wr=%b bz=%b addr=%0d, want 1 1 0", wren_a, busy_a, addr_a);
        end
        tick();
        n_tests++;
        if ({sp_a, done_a, restore_a, unf_a} !== {6'd1, 1'b1, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_done: sp=%0d dn=%b re=%b un=%b, want 1 1 0 1", sp_a, done_a, restore_a, unf_a);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        push_a = 1'b1;
        tick();
        n_tests++;
        if ({wren_a, addr_a} !== {1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL b2b_wr0: wr=%b addr=%0d, want 1 1", wren_a, addr_a);
        end
        tick();
        n_tests++;
        if ({done_a, sp_a, wren_a} !== {1'b1, 6'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_done0: dn=%b sp=%0d wr=%b, want 1 2 0", done_a, sp_a, wren_a);
        end
        tick();
        push_a = 1'b0;
        n_tests++;
        if ({wren_a, addr_a, done_a} !== {1'b1, 5'd2, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_wr1: wr=%b addr=%0d dn=%b, want 1 2 0", wren_a, addr_a, done_a);
        end
        tick();
        n_tests++;
        if ({done_a, sp_a} !== {1'b1, 6'd3}) begin
            n_fail++;
            $display("FAIL b2b_done1: dn=%b sp=%0d, want 1 3", done_a, sp_a);
        end
        tick();
    endtask

    task automatic test_flush_pop_rd();
        pop_b = 1'b1;
        tick();
        pop_b = 1'b0;
        n_tests++;
        if ({busy_b, addr_b} !== {1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL fpop_rd: bz=%b addr=%0d, want 1 1", busy_b, addr_b);
        end
        flush_b = 1'b1;
        tick();
        flush_b = 1'b0;
        n_tests++;
        if ({sp_b, busy_b, restore_b, done_b, empty_b} !== {6'd0, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL fpop_flush: sp=%0d bz=%b re=%b dn=%b e=%b, want 0 0 0 0 1", sp_b, busy_b, restore_b, done_b, empty_b);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({restore_b, done_b, busy_b} !== 3'b000) begin
                n_fail++;
                $display("FAIL fpop_quiet[%0d]: re=%b dn=%b bz=%b, want 0 0 0", i, restore_b, done_b, busy_b);
            end
        end
    endtask

    task automatic test_reset_push_wr();
        do_push_b();
        push_b = 1'b1;
        tick();
        push_b = 1'b0;
        n_tests++;
        if ({wren_b, addr_b} !== {1'b1, 5'd1}) begin
            n_fail++;
            $display("FAIL rpush_wr: wr=%b addr=%0d, want 1 1", wren_b, addr_b);
        end
        #1;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({wren_b, busy_b, sp_b, addr_b, done_b} !== {1'b0, 1'b0, 6'd0, 5'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL rpush_async: wr=%b bz=%b sp=%0d addr=%0d dn=%b, want 0 0 0 0 0",
                     wren_b, busy_b, sp_b, addr_b, done_b);
        end
        #1;
        rst_n = 1'b1;
        tick();
        n_tests++;
        if ({wren_b, done_b, sp_b} !== {1'b0, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL rpush_after: wr=%b dn=%b sp=%0d, want 0 0 0", wren_b, done_b, sp_b);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests   = 0;
        n_fail    = 0;
        push_a    = 1'b0;
        pop_a     = 1'b0;
        flush_a   = 1'b0;
        err_clr_a = 1'b0;
        push_b    = 1'b0;
        pop_b     = 1'b0;
        flush_b   = 1'b0;
        err_clr_b = 1'b0;
        test_reset();
        test_single_push();
        test_pop_lat1();
        test_pop_lat2();
        test_fill_overflow();
        test_underflow_simul();
        test_back_to_back();
        test_flush_pop_rd();
        test_reset_push_wr();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
